// File: rtl/seq_alu.sv
// Handshaked ALU: AND/OR/ADD-class/SUB-class in one step, MUL as iterative shift-add.
// Latency: 1 cycle issue-to-valid for single-cycle ops, WIDTH cycles for MUL.
// Backpressure: result and flags held in DONE until ready_i; ready_o follows ready_i in DONE, low during MUL.
module seq_alu #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WIDTH-1:0]  data1_i,
    input  logic [WIDTH-1:0]  data2_i,
    input  logic [CTRL_W-1:0] control_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              zero_o,
    output logic              ovf_o,
    output logic              err_o
);

    // Operation encodings shared with the decoder
    localparam logic [CTRL_W-1:0] CTRL_AND  = CTRL_W'(4'h0);
    localparam logic [CTRL_W-1:0] CTRL_OR   = CTRL_W'(4'h1);
    localparam logic [CTRL_W-1:0] CTRL_ADD  = CTRL_W'(4'h2);
    localparam logic [CTRL_W-1:0] CTRL_MUL  = CTRL_W'(4'h3);
    localparam logic [CTRL_W-1:0] CTRL_ADDI = CTRL_W'(4'h4);
    localparam logic [CTRL_W-1:0] CTRL_LW   = CTRL_W'(4'h5);
    localparam logic [CTRL_W-1:0] CTRL_SUB  = CTRL_W'(4'h6);
    localparam logic [CTRL_W-1:0] CTRL_SW   = CTRL_W'(4'h7);
    localparam logic [CTRL_W-1:0] CTRL_BEQ  = CTRL_W'(4'h8);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;

    logic              issue;
    logic              is_mul;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_ovf;
    logic              alu_err;
    logic [WIDTH-1:0]  acc_step;
    logic [WIDTH-1:0]  sum;
    logic [WIDTH-1:0]  diff;

    assign issue  = valid_i && ready_o;
    assign is_mul = (control_i == CTRL_MUL);
    assign sum    = data1_i + data2_i;
    assign diff   = data1_i - data2_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: DONE with a same-cycle issue re-enters via the IDLE rules
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (issue) state_d = is_mul ? S_MUL_RUN : S_DONE;
            S_MUL_RUN: if (cnt_q == '0) state_d = S_DONE;
            S_DONE: begin
                if (issue)        state_d = is_mul ? S_MUL_RUN : S_DONE;
                else if (ready_i) state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            S_IDLE:  ready_o = 1'b1;
            S_DONE: begin
                ready_o = ready_i;
                valid_o = 1'b1;
            end
            default: ready_o = 1'b0;
        endcase
    end

    // Single-cycle result, overflow and illegal-op decode
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        case (control_i)
            CTRL_AND: alu_res = data1_i & data2_i;
            CTRL_OR:  alu_res = data1_i | data2_i;
            CTRL_ADD, CTRL_ADDI, CTRL_LW, CTRL_SW: begin
                alu_res = sum;
                alu_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) &&
                          (sum[WIDTH-1] != data1_i[WIDTH-1]);
            end
            CTRL_SUB, CTRL_BEQ: begin
                alu_res = diff;
                alu_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) &&
                          (diff[WIDTH-1] != data1_i[WIDTH-1]);
            end
            CTRL_MUL: alu_res = '0;
            default:  alu_err = 1'b1;
        endcase
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Datapath next values: capture on issue, one shift-add step per MUL_RUN cycle
    always_comb begin
        data_d   = data_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (issue) begin
            if (is_mul) begin
                cnt_d    = CNT_W'(WIDTH - 1);
                acc_d    = '0;
                mcand_d  = data1_i;
                mplier_d = data2_i;
            end else begin
                data_d = alu_res;
                zero_d = (alu_res == '0);
                ovf_d  = alu_ovf;
                err_d  = alu_err;
            end
        end else if (state_q == S_MUL_RUN) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                data_d = acc_step;
                zero_d = (acc_step == '0);
                ovf_d  = 1'b0;
                err_d  = 1'b0;
            end
        end
    end

    // Datapath registers; reset clears result and aborts any multiply in flight
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q   <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            data_q   <= data_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign data_o = data_q;
    assign zero_o = zero_q;
    assign ovf_o  = ovf_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 and WIDTH=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
module tb_seq_alu;

    localparam logic [3:0] C_AND = 4'h0;
    localparam logic [3:0] C_OR  = 4'h1;
    localparam logic [3:0] C_ADD = 4'h2;
    localparam logic [3:0] C_MUL = 4'h3;
    localparam logic [3:0] C_SUB = 4'h6;
    localparam logic [3:0] C_BEQ = 4'h8;
    localparam logic [3:0] C_BAD = 4'hF;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        v32 = 1'b0, ri32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0;
    logic [3:0]  c32 = '0;
    logic        ro32, vo32, z32, ov32, er32;
    logic [31:0] d32;

    logic        v8 = 1'b0, ri8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [3:0]  c8 = '0;
    logic        ro8, vo8, z8, ov8, er8;
    logic [7:0]  d8;

    int n_checks = 0;
    int n_errors = 0;
    logic bad;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32), .CTRL_W(4)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(v32), .ready_o(ro32),
        .data1_i(a32), .data2_i(b32), .control_i(c32), .valid_o(vo32),
        .ready_i(ri32), .data_o(d32), .zero_o(z32), .ovf_o(ov32), .err_o(er32)
    );

    seq_alu #(.WIDTH(8), .CTRL_W(4)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(v8), .ready_o(ro8),
        .data1_i(a8), .data2_i(b8), .control_i(c8), .valid_o(vo8),
        .ready_i(ri8), .data_o(d8), .zero_o(z8), .ovf_o(ov8), .err_o(er8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_valid", {31'd0, vo32}, 32'd0);
        check("rst_data", d32, 32'd0);
        check("rst_flags", {29'd0, z32, ov32, er32}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("ready_after_rst", {31'd0, ro32}, 32'd1);

        // ADD with signed overflow
        v32 = 1'b1; a32 = 32'h7FFF_FFFF; b32 = 32'd1; c32 = C_ADD;
        tick();
        v32 = 1'b0;
        check("add_valid", {31'd0, vo32}, 32'd1);
        check("add_data", d32, 32'h8000_0000);
        check("add_flags", {29'd0, z32, ov32, er32}, 32'b010);
        tick();
        check("add_drop_valid", {31'd0, vo32}, 32'd0);

        // BEQ equal operands -> zero
        v32 = 1'b1; a32 = 32'h1234; b32 = 32'h1234; c32 = C_BEQ;
        tick();
        v32 = 1'b0;
        check("beq_data", d32, 32'd0);
        check("beq_flags", {29'd0, z32, ov32, er32}, 32'b100);
        tick();

        // SUB with signed overflow
        v32 = 1'b1; a32 = 32'h8000_0000; b32 = 32'd1; c32 = C_SUB;
        tick();
        v32 = 1'b0;
        check("sub_data", d32, 32'h7FFF_FFFF);
        check("sub_ovf", {31'd0, ov32}, 32'd1);
        tick();

        // MUL -1 * 7, latency 32
        v32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'd7; c32 = C_MUL;
        tick();
        v32 = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (vo32 !== 1'b0 || ro32 !== 1'b0) bad = 1'b1;
            tick();
        end
        check("mul_busy", {31'd0, bad}, 32'd0);
        check("mul_valid_at_32", {31'd0, vo32}, 32'd1);
        check("mul_data", d32, 32'hFFFF_FFF9);
        check("mul_flags", {29'd0, z32, ov32, er32}, 32'b000);
        tick();

        // Backpressure on AND, then accept with same-cycle OR issue
        ri32 = 1'b0;
        v32 = 1'b1; a32 = 32'hF0F0; b32 = 32'hFF00; c32 = C_AND;
        tick();
        v32 = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (vo32 !== 1'b1 || ro32 !== 1'b0 || d32 !== 32'hF000) bad = 1'b1;
            tick();
        end
        check("and_held", {31'd0, bad}, 32'd0);
        ri32 = 1'b1;
        v32 = 1'b1; a32 = 32'd1; b32 = 32'd2; c32 = C_OR;
        #1;
        check("ready_follows_ready_i", {31'd0, ro32}, 32'd1);
        tick();
        v32 = 1'b0;
        check("or_b2b_valid", {31'd0, vo32}, 32'd1);
        check("or_b2b_data", d32, 32'd3);
        tick();

        // Illegal control, then a legal op clears err
        v32 = 1'b1; a32 = 32'd5; b32 = 32'd6; c32 = C_BAD;
        tick();
        check("ill_valid", {31'd0, vo32}, 32'd1);
        check("ill_data", d32, 32'd0);
        check("ill_flags", {29'd0, z32, ov32, er32}, 32'b101);
        a32 = 32'd1; b32 = 32'd1; c32 = C_ADD;
        tick();
        v32 = 1'b0;
        check("legal_clears_err", {31'd0, er32}, 32'd0);
        check("legal_data", d32, 32'd2);
        tick();

        // Reset during a MUL run
        v32 = 1'b1; a32 = 32'd3; b32 = 32'd5; c32 = C_MUL;
        tick();
        v32 = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, vo32}, 32'd0);
        check("rst_mid_data", d32, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_ready", {31'd0, ro32}, 32'd1);
        v32 = 1'b1; a32 = 32'd2; b32 = 32'd3; c32 = C_ADD;
        tick();
        v32 = 1'b0;
        check("post_rst_add_valid", {31'd0, vo32}, 32'd1);
        check("post_rst_add", d32, 32'd5);
        tick();

        // WIDTH=8: ADD overflow
        v8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; c8 = C_ADD;
        tick();
        v8 = 1'b0;
        check("w8_add_data", {24'd0, d8}, 32'h80);
        check("w8_add_ovf", {31'd0, ov8}, 32'd1);
        tick();

        // WIDTH=8: MUL 0x10 * 0x10 truncates to 0, latency 8
        v8 = 1'b1; a8 = 8'h10; b8 = 8'h10; c8 = C_MUL;
        tick();
        v8 = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (vo8 !== 1'b0 || ro8 !== 1'b0) bad = 1'b1;
            tick();
        end
        check("w8_mul_busy", {31'd0, bad}, 32'd0);
        check("w8_mul_valid_at_8", {31'd0, vo8}, 32'd1);
        check("w8_mul_data", {24'd0, d8}, 32'h00);
        check("w8_mul_zero", {31'd0, z8}, 32'd1);
        tick();

        // WIDTH=8: MUL 0x0F * 0x03 = 0x2D
        v8 = 1'b1; a8 = 8'h0F; b8 = 8'h03; c8 = C_MUL;
        tick();
        v8 = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("w8_mul2_data", {24'd0, d8}, 32'h2D);
        check("w8_mul2_zero", {31'd0, z8}, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
